i2s2_rx: RTL and testbench

I2S2_RX -- requirements
Module: i2s2_rx

---
 rtl/i2s2_rx.sv | 121 ++++++++++++
 tb/tb_i2s2_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2s2_rx.sv
// I2S receiver master: forwards mclk, generates sclk/lrck, deserialises stereo samples.
// Optional overrun detection is enabled by defining I2S2_RX_OVERRUN_EN.
module i2s2_rx #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SCLK_DIV     = 12
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    sdout_in,
  input  logic                    ready_in,
  output logic                    mclk_out,
  output logic                    sclk_out,
  output logic                    lrck_out,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    valid_out,
  output logic                    overrun_out
);

  localparam int unsigned DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DLast   = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DSample = DW'(SCLK_DIV - 2);
  localparam logic [DW-1:0] DHalf   = DW'(SCLK_DIV / 2);
  localparam logic [5:0] CommitSlot = 6'(32 + SAMPLE_WIDTH);
  localparam logic [4:0] LastBit    = 5'(SAMPLE_WIDTH);

  logic [DW-1:0]           d_q, d_d;
  logic [5:0]              s_q, s_d;
  logic                    sclk_q, sclk_d;
  logic                    lrck_q, lrck_d;
  logic [SAMPLE_WIDTH-1:0] lsr_q, lsr_d;
  logic [SAMPLE_WIDTH-1:0] rsr_q, rsr_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;
  logic                    wrap, sample, in_data, commit;
  logic [4:0]              slot;

  always_comb begin
    wrap    = (d_q == DLast);
    d_d     = wrap ? '0 : d_q + 1'b1;
    s_d     = wrap ? s_q + 6'd1 : s_q;
    // Registered from next-state so sclk/lrck line up with the counters.
    sclk_d  = (d_d >= DHalf);
    lrck_d  = s_d[5];

    slot    = s_q[4:0];
    in_data = (slot != 5'd0) && (slot <= LastBit);
    sample  = (d_q == DSample) && in_data;
    commit  = (s_q == CommitSlot) && wrap;

    lsr_d = lsr_q;
    rsr_d = rsr_q;
    if (sample && !s_q[5]) lsr_d = {lsr_q[SAMPLE_WIDTH-2:0], sdout_in};
    if (sample && s_q[5])  rsr_d = {rsr_q[SAMPLE_WIDTH-2:0], sdout_in};

    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (commit) begin
      if (!valid_q || ready_in) begin
        left_d  = lsr_q;
        right_d = rsr_q;
        valid_d = 1'b1;
      end else begin
`ifdef I2S2_RX_OVERRUN_EN
        ovr_d   = 1'b1;
`else
        left_d  = lsr_q;
        right_d = rsr_q;
`endif
      end
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      d_q     <= '0;
      s_q     <= '0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      lsr_q   <= '0;
      rsr_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      s_q     <= s_d;
      sclk_q  <= sclk_d;
      lrck_q  <= lrck_d;
      lsr_q   <= lsr_d;
      rsr_q   <= rsr_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

`ifdef I2S2_RX_OVERRUN_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ovr_q <= 1'b0;
    else           ovr_q <= ovr_d;
  end
`else
  assign ovr_q = 1'b0;
`endif

  assign mclk_out    = clk_in;
  assign sclk_out    = sclk_q;
  assign lrck_out    = lrck_q;
  assign left_out    = left_q;
  assign right_out   = right_q;
  assign valid_out   = valid_q;
  assign overrun_out = ovr_q;

endmodule

// File: tb/tb_i2s2_rx.sv
// Self-checking bench for i2s2_rx: cycle-indexed reference model plus table and handshake cases.
module tb_i2s2_rx;
  localparam int unsigned SW    = 24;
  localparam int unsigned DIV   = 12;
  localparam int unsigned FRAME = 64 * DIV;
  localparam int unsigned COFF  = (32 + SW) * DIV + DIV - 1;  // commit cycle within a frame

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sdout = 1'b0;
  logic          ready = 1'b0;
  logic          mclk, sclk, lrck, valid, ovr;
  logic [SW-1:0] left, right;

  i2s2_rx #(.SAMPLE_WIDTH(SW), .SCLK_DIV(DIV)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .sdout_in    (sdout),
    .ready_in    (ready),
    .mclk_out    (mclk),
    .sclk_out    (sclk),
    .lrck_out    (lrck),
    .left_out    (left),
    .right_out   (right),
    .valid_out   (valid),
    .overrun_out (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    bit            fill;
  } vec_t;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   c = 0;
  bit            run = 1'b0;
  logic [SW-1:0] ldat[16];
  logic [SW-1:0] rdat[16];
  bit            fill1[16];
  bit            m_valid, m_ovr;
  logic [SW-1:0] m_l, m_r;
  vec_t          tab[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (c=%0d)", name, act, exp, c);
    end
  endtask

  // ADC model: bit driven during cycle cc, derived from slot position and frame data.
  function automatic bit src_bit(input int unsigned cc);
    int unsigned f    = (cc / FRAME) % 16;
    int unsigned slot = (cc / DIV) % 64;
    int unsigned k    = slot % 32;
    if (k >= 1 && k <= SW) return (slot < 32) ? ldat[f][SW-k] : rdat[f][SW-k];
    return fill1[f] ? 1'b1 : 1'($urandom_range(1, 0));
  endfunction

  always @(negedge clk) begin : mon
    int unsigned f;
    bit exp_sclk, exp_lrck;
    if (run && rst_n) begin
      if ((c % FRAME) == COFF) begin
        f = (c / FRAME) % 16;
        if (!m_valid || ready) begin
          m_l = ldat[f]; m_r = rdat[f]; m_valid = 1'b1;
        end else begin
`ifdef I2S2_RX_OVERRUN_EN
          m_ovr = 1'b1;
`else
          m_l = ldat[f]; m_r = rdat[f];
`endif
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      c++;
      exp_sclk = (c % DIV) >= (DIV / 2);
      exp_lrck = ((c / DIV) % 64) >= 32;
      check("cycle_state", {12'd0, sclk, lrck, valid, ovr, left, right},
            {12'd0, exp_sclk, exp_lrck, m_valid, m_ovr, m_l, m_r});
      sdout = src_bit(c);
    end
  end

  task automatic wait_c(input int unsigned t);
    while (c < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    c = 0;
    m_valid = 1'b0; m_ovr = 1'b0; m_l = '0; m_r = '0;
    sdout = src_bit(0);
    rst_n = 1'b1;
    run = 1'b1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, 64'(valid), 64'd0);
    check({name, "_left"}, 64'(left), 64'd0);
    check({name, "_right"}, 64'(right), 64'd0);
    check({name, "_ovr"}, 64'(ovr), 64'd0);
    check({name, "_sclk"}, 64'(sclk), 64'd0);
    check({name, "_lrck"}, 64'(lrck), 64'd0);
  endtask

  initial begin
    int unsigned n;
    tab[0] = '{24'h800001, 24'h7FFFFE, 1'b0};
    tab[1] = '{24'h000000, 24'h000000, 1'b1};
    tab[2] = '{SW'($urandom()), SW'($urandom()), 1'b0};
    tab[3] = '{SW'($urandom()), SW'($urandom()), 1'b0};
    tab[4] = '{24'hFFFFFF, 24'h000000, 1'b0};
    for (int i = 0; i < 16; i++) begin
      ldat[i] = SW'($urandom()); rdat[i] = SW'($urandom()); fill1[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      ldat[i] = tab[i].l; rdat[i] = tab[i].r; fill1[i] = tab[i].fill;
    end

    #2 rst_n = 1'b0;
    #20 check_zero("reset");
    ready = 1'b1;
    release_rst();

    for (int i = 0; i < 5; i++) begin
      wait_c(i * FRAME + COFF + 1);
      check($sformatf("tab%0d_left", i), 64'(left), 64'(tab[i].l));
      check($sformatf("tab%0d_right", i), 64'(right), 64'(tab[i].r));
      check($sformatf("tab%0d_valid", i), 64'(valid), 64'd1);
    end

    // Unacknowledged pair, then ready only in the commit cycle: new pair loads.
    wait_c(5 * FRAME);
    ready = 1'b0;
    wait_c(5 * FRAME + COFF + 1);
    check("hold5_left", 64'(left), 64'(ldat[5]));
    wait_c(6 * FRAME + COFF);
    ready = 1'b1;
    wait_c(6 * FRAME + COFF + 1);
    ready = 1'b0;
    check("commit_rdy_valid", 64'(valid), 64'd1);
    check("commit_rdy_left", 64'(left), 64'(ldat[6]));
    check("commit_rdy_right", 64'(right), 64'(rdat[6]));
    check("commit_rdy_ovr", 64'(ovr), 64'd0);

    // Commit while stalled.
    wait_c(7 * FRAME + COFF + 1);
    check("stall_valid", 64'(valid), 64'd1);
`ifdef I2S2_RX_OVERRUN_EN
    check("stall_left", 64'(left), 64'(ldat[6]));
    check("stall_ovr", 64'(ovr), 64'd1);
`else
    check("stall_left", 64'(left), 64'(ldat[7]));
    check("stall_ovr", 64'(ovr), 64'd0);
`endif
    wait_c(8 * FRAME + 100);
    ready = 1'b1;
    wait_c(8 * FRAME + 101);
    check("ack_drop_valid", 64'(valid), 64'd0);

    // Asynchronous reset in the right half-frame (s = 40).
    wait_c(9 * FRAME + 40 * DIV + 3);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (3) @(negedge clk);
    release_rst();
    n = 0;
    while (!valid && n < 2 * FRAME) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("post_reset_latency", 64'(c), 64'(COFF + 1));
    check("post_reset_left", 64'(left), 64'(ldat[0]));
    check("post_reset_right", 64'(right), 64'(rdat[0]));
    wait_c(FRAME + COFF + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
